// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, paddle FSM states and button decode.
package pong_pkg;

  localparam int Y_W      = 10;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_H = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    BOTH = 2'd3
  } paddle_state_t;

  function automatic paddle_state_t decode_buttons(input logic up, input logic down);
    case ({up, down})
      2'b10:   return UP;
      2'b01:   return DOWN;
      2'b11:   return BOTH;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw push button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // The level only flips once the synchronized input has disagreed with it
  // for DEBOUNCE_CYCLES edges in a row; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: debounced up/down buttons drive a per-frame paddle move
// with clamping at the screen edges and step doubling after sustained motion.
module paddle_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int Y_W             = pong_pkg::Y_W,
  parameter int SCREEN_H        = pong_pkg::SCREEN_H,
  parameter int PADDLE_H        = pong_pkg::PADDLE_H,
  parameter int STEP            = 4,
  parameter int ACCEL_FRAMES    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           but_up,
  input  logic           but_down,
  input  logic           frame_tick,
  output logic [Y_W-1:0] paddle_y,
  output logic           up_db,
  output logic           down_db,
  output logic           moving
);

  import pong_pkg::paddle_state_t;
  import pong_pkg::IDLE;
  import pong_pkg::UP;
  import pong_pkg::DOWN;
  import pong_pkg::decode_buttons;

  localparam int             AW      = $clog2(ACCEL_FRAMES + 1);
  localparam logic [Y_W:0]   Y_MAX   = (Y_W + 1)'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0] Y_RESET = Y_W'((SCREEN_H - PADDLE_H) / 2);

  paddle_state_t  state;
  paddle_state_t  state_nxt;
  logic [AW-1:0]  accel;
  logic [Y_W:0]   step;
  logic [Y_W:0]   y_ext;
  logic [Y_W-1:0] y_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (but_up),
    .level (up_db)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (but_down),
    .level (down_db)
  );

  // One extra bit of headroom so neither the subtract nor the add can wrap.
  always_comb begin
    state_nxt = decode_buttons(up_db, down_db);
    step      = (accel == AW'(ACCEL_FRAMES)) ? (Y_W + 1)'(2 * STEP) : (Y_W + 1)'(STEP);
    y_ext     = {1'b0, paddle_y};
    y_next    = paddle_y;
    case (state)
      UP: begin
        if (y_ext < step) y_next = '0;
        else              y_next = Y_W'(y_ext - step);
      end
      DOWN: begin
        if (y_ext + step > Y_MAX) y_next = Y_W'(Y_MAX);
        else                      y_next = Y_W'(y_ext + step);
      end
      default: y_next = paddle_y;
    endcase
  end

  // A move uses the state held during the tick cycle, so a state change on the
  // same edge only affects the following frame; clearing accel wins over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      moving   <= 1'b0;
      accel    <= '0;
      paddle_y <= Y_RESET;
    end else begin
      state  <= state_nxt;
      moving <= (state_nxt == UP) || (state_nxt == DOWN);
      if (frame_tick) paddle_y <= y_next;
      if (state_nxt != state) begin
        accel <= '0;
      end else if (frame_tick && ((state == UP) || (state == DOWN)) &&
                   (accel != AW'(ACCEL_FRAMES))) begin
        accel <= accel + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus randomized button
// activity, all compared against a frame-level behavioural model.
module tb_paddle_ctrl;

  localparam int N    = 16;
  localparam int S    = 4;
  localparam int A    = 8;
  localparam int YMAX = 416;
  localparam int YRST = 208;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       but_up = 1'b0;
  logic       but_down = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle_y;
  logic       up_db;
  logic       down_db;
  logic       moving;

  int vectors = 0;
  int miscompares = 0;

  paddle_ctrl #(
    .DEBOUNCE_CYCLES (N),
    .Y_W             (10),
    .SCREEN_H        (480),
    .PADDLE_H        (64),
    .STEP            (S),
    .ACCEL_FRAMES    (A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .but_up     (but_up),
    .but_down   (but_down),
    .frame_tick (frame_tick),
    .paddle_y   (paddle_y),
    .up_db      (up_db),
    .down_db    (down_db),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample history for the debouncers, button pair as the
  // motion mode, and plain integer clamping for the paddle position.
  bit         hist_u[$];
  bit         hist_d[$];
  logic       m_up_db, m_dn_db, m_moving;
  logic [1:0] m_st, old_st, new_st;
  int         m_y, m_accel, m_step;

  function automatic bit flips(input bit q[$], input logic lvl);
    for (int i = 0; i < N; i++) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_up_db  = 1'b0;
      m_dn_db  = 1'b0;
      m_moving = 1'b0;
      m_st     = 2'b00;
      m_y      = YRST;
      m_accel  = 0;
      hist_u.delete();
      hist_d.delete();
      for (int i = 0; i < N + 2; i++) begin
        hist_u.push_back(1'b0);
        hist_d.push_back(1'b0);
      end
    end else begin
      old_st = m_st;
      new_st = {m_up_db, m_dn_db};
      if (frame_tick && (old_st == 2'b10 || old_st == 2'b01)) begin
        m_step = (m_accel == A) ? 2 * S : S;
        if (old_st == 2'b10) m_y = (m_y < m_step) ? 0 : m_y - m_step;
        else                 m_y = (m_y + m_step > YMAX) ? YMAX : m_y + m_step;
        if (m_accel < A) m_accel++;
      end
      if (new_st != old_st) m_accel = 0;
      m_st     = new_st;
      m_moving = new_st[1] ^ new_st[0];
      hist_u.push_back(but_up);
      hist_d.push_back(but_down);
      void'(hist_u.pop_front());
      void'(hist_d.pop_front());
      if (flips(hist_u, m_up_db)) m_up_db = ~m_up_db;
      if (flips(hist_d, m_dn_db)) m_dn_db = ~m_dn_db;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int gap);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; but_up = 1'b0; but_down = 1'b0; frame_tick = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycles(3);
    vectors++;
    if (paddle_y !== 10'(YRST)) begin
      miscompares++;
      $display("[TB] FAIL reset_y: got %0d expected %0d", paddle_y, YRST);
    end
    vectors++;
    if ({up_db, down_db, moving} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {up_db, down_db, moving});
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick(19);
    vectors++;
    if (paddle_y !== 10'(YRST) || moving !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ticks: got y=%0d moving=%b expected y=%0d moving=0",
               paddle_y, moving, YRST);
    end
  endtask

  task automatic test_debounce_accel();
    int rise = -1;
    int exp_y[10] = '{204, 200, 196, 192, 188, 184, 180, 176, 168, 160};
    but_up = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (up_db === 1'b1 && rise < 0) rise = c;
    end
    vectors++;
    if (rise != 2 + N) begin
      miscompares++;
      $display("[TB] FAIL press_latency: got %0d expected %0d", rise, 2 + N);
    end
    for (int i = 0; i < 10; i++) begin
      tick(49);
      vectors++;
      if (paddle_y !== 10'(exp_y[i]) || paddle_y !== 10'(m_y)) begin
        miscompares++;
        $display("[TB] FAIL accel_tick%0d: got %0d expected %0d (model %0d)",
                 i, paddle_y, exp_y[i], m_y);
      end
    end
    but_up = 1'b0;
    cycles(25);
    vectors++;
    if (moving !== 1'b0 || up_db !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_up: got moving=%b up_db=%b expected 0 0", moving, up_db);
    end
  endtask

  task automatic test_glitch();
    int hits = 0;
    int y0;
    y0 = m_y;
    for (int p = 0; p < 6; p++) begin
      but_down = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (down_db !== 1'b0) hits++;
      end
      but_down = 1'b0;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (down_db !== 1'b0) hits++;
      repeat (2) begin
        @(negedge clk);
        if (down_db !== 1'b0) hits++;
      end
    end
    cycles(20);
    vectors++;
    if (hits != 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_db: got %0d high cycles expected 0", hits);
    end
    vectors++;
    if (paddle_y !== 10'(y0) || paddle_y !== 10'(m_y)) begin
      miscompares++;
      $display("[TB] FAIL glitch_y: got %0d expected %0d", paddle_y, y0);
    end
  endtask

  task automatic test_both();
    do_reset();
    but_up = 1'b1;
    cycles(22);
    for (int i = 0; i < 3; i++) tick(3);
    but_down = 1'b1;
    cycles(22);
    vectors++;
    if (moving !== 1'b0 || down_db !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL both_state: got moving=%b down_db=%b expected 0 1", moving, down_db);
    end
    for (int i = 0; i < 3; i++) tick(3);
    vectors++;
    if (paddle_y !== 10'd196) begin
      miscompares++;
      $display("[TB] FAIL both_hold: got %0d expected 196", paddle_y);
    end
    but_down = 1'b0;
    cycles(22);
    tick(3);
    vectors++;
    if (paddle_y !== 10'd192 || moving !== 1'b1 || paddle_y !== 10'(m_y)) begin
      miscompares++;
      $display("[TB] FAIL both_to_up: got y=%0d moving=%b expected y=192 moving=1",
               paddle_y, moving);
    end
    but_up = 1'b0;
    cycles(22);
  endtask

  task automatic test_clamp();
    do_reset();
    but_up = 1'b1; cycles(22); tick(3);
    but_up = 1'b0; cycles(22);
    but_up = 1'b1; cycles(22);
    for (int i = 1; i <= 31; i++) begin
      tick(2);
      vectors++;
      if (paddle_y !== 10'(m_y) || (i == 29 && paddle_y !== 10'd4) ||
          (i >= 30 && paddle_y !== 10'd0)) begin
        miscompares++;
        $display("[TB] FAIL clamp_top%0d: got %0d model %0d", i, paddle_y, m_y);
      end
    end
    but_up = 1'b0; cycles(22);
    but_down = 1'b1; cycles(22); tick(3);
    but_down = 1'b0; cycles(22);
    but_down = 1'b1; cycles(22);
    for (int i = 1; i <= 57; i++) begin
      tick(2);
      vectors++;
      if (paddle_y !== 10'(m_y) || (i == 55 && paddle_y !== 10'd412) ||
          (i >= 56 && paddle_y !== 10'(YMAX))) begin
        miscompares++;
        $display("[TB] FAIL clamp_bot%0d: got %0d model %0d", i, paddle_y, m_y);
      end
    end
    but_down = 1'b0;
    cycles(22);
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    but_up = 1'b1; cycles(22); tick(3);
    but_up = 1'b0; cycles(22);
    but_up = 1'b1; cycles(22);
    for (int i = 0; i < 17; i++) tick(2);
    vectors++;
    if (paddle_y !== 10'd100 || moving !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset: got y=%0d moving=%b expected y=100 moving=1",
               paddle_y, moving);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (paddle_y !== 10'(YRST) || {up_db, moving} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got y=%0d up_db=%b moving=%b expected y=%0d 0 0",
               paddle_y, up_db, moving, YRST);
    end
    but_up = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 60; seg++) begin
      but_up   = 1'($urandom_range(0, 1));
      but_down = 1'($urandom_range(0, 1));
      len      = int'($urandom_range(1, 40));
      for (int c = 0; c < len; c++) begin
        frame_tick = ($urandom_range(0, 5) == 0);
        @(negedge clk);
        vectors++;
        if (paddle_y !== 10'(m_y) ||
            {up_db, down_db, moving} !== {m_up_db, m_dn_db, m_moving}) begin
          miscompares++;
          if (miscompares < 20)
            $display("[TB] FAIL random_seg%0d: got y=%0d flags=%b expected y=%0d flags=%b",
                     seg, paddle_y, {up_db, down_db, moving}, m_y,
                     {m_up_db, m_dn_db, m_moving});
        end
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce_accel();
    test_glitch();
    test_both();
    test_clamp();
    test_reset_mid_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
